hdr_pin_ctrl: RTL and testbench

//  Parametrised header-pin controller between the NEORV32 processor and a board connector (Arduino/GPIO header).
//  Per-pin runtime mode (hi-Z, input, output, peripheral), input synchronisation, optional glitch filter and edge events.

---
 rtl/hdr_pin_ctrl.sv | 153 +++++++++++++++
 tb/tb_hdr_pin_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_pin_ctrl.sv
// Header-pin controller: per-pin runtime mode, synchronised (optionally glitch-filtered) inputs, edge events, UART0 routing.
// Define HDR_PIN_FILTER_EN to add the per-pin glitch filter (input latency SYNC_STAGES+FILT_CYCLES instead of SYNC_STAGES).
module hdr_pin_ctrl #(
  parameter  int NUM_PINS    = 16,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILT_CYCLES = 4,
  parameter  int UART_TX_PIN = 1,
  parameter  int UART_RX_PIN = 0,
  localparam int AW          = $clog2(NUM_PINS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [1:0]          cfg_mode_i,
  output logic [1:0]          cfg_rdata_o,
  input  logic [NUM_PINS-1:0] core_out_i,
  output logic [NUM_PINS-1:0] core_in_o,
  input  logic [NUM_PINS-1:0] pad_i,
  output logic [NUM_PINS-1:0] pad_o,
  output logic [NUM_PINS-1:0] pad_oe_o,
  input  logic                uart_txd_i,
  output logic                uart_rxd_o,
  input  logic [NUM_PINS-1:0] evt_mask_i,
  input  logic [NUM_PINS-1:0] evt_clr_i,
  output logic [NUM_PINS-1:0] evt_pend_o,
  output logic                irq_o
);

  localparam logic [1:0] M_HIZ    = 2'b00;
  localparam logic [1:0] M_OUT    = 2'b10;
  localparam logic [1:0] M_PERIPH = 2'b11;

  if (UART_TX_PIN == UART_RX_PIN || UART_TX_PIN >= NUM_PINS || UART_RX_PIN >= NUM_PINS) begin : g_bad_uart
    $error("hdr_pin_ctrl: UART pins must be distinct and below NUM_PINS");
  end
  if (NUM_PINS < 2 || NUM_PINS > 64 || SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_bad_param
    $error("hdr_pin_ctrl: parameter out of range");
  end

  logic [1:0]          mode_q   [NUM_PINS];
  logic [1:0]          mode_nxt [NUM_PINS];
  logic [NUM_PINS-1:0] sync_q   [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_out, cond, cond_eff, pin_en;
  logic [NUM_PINS-1:0] prev_q, pend_q, oe_q, po_q, oe_nxt, po_nxt;
  logic [1:0]          rdata_q, rdata_nxt;
  logic                irq_q, addr_ok;

  assign addr_ok = (int'(cfg_addr_i) < NUM_PINS);

  // Outputs and readback are registered from the post-write mode so a write is visible one cycle later.
  always_comb begin
    for (int n = 0; n < NUM_PINS; n++) mode_nxt[n] = mode_q[n];
    if (cfg_we_i && addr_ok) mode_nxt[cfg_addr_i] = cfg_mode_i;
    rdata_nxt = addr_ok ? mode_nxt[cfg_addr_i] : 2'b00;
    oe_nxt = '0;
    po_nxt = '0;
    for (int n = 0; n < NUM_PINS; n++) begin
      if (mode_nxt[n] == M_OUT) begin
        oe_nxt[n] = 1'b1;
        po_nxt[n] = core_out_i[n];
      end else if (mode_nxt[n] == M_PERIPH && n == UART_TX_PIN) begin
        oe_nxt[n] = 1'b1;
        po_nxt[n] = uart_txd_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_PINS; n++) mode_q[n] <= M_HIZ;
      rdata_q <= 2'b00;
      oe_q    <= '0;
      po_q    <= '0;
    end else begin
      for (int n = 0; n < NUM_PINS; n++) mode_q[n] <= mode_nxt[n];
      rdata_q <= rdata_nxt;
      oe_q    <= oe_nxt;
      po_q    <= po_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef HDR_PIN_FILTER_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [CW-1:0]       cnt_q [NUM_PINS];
  logic [NUM_PINS-1:0] filt_q;

  // Filtered value only follows after FILT_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= '0;
      for (int n = 0; n < NUM_PINS; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_PINS; n++) begin
        if (sync_out[n] != filt_q[n]) begin
          if (cnt_q[n] == CW'(FILT_CYCLES - 1)) begin
            filt_q[n] <= sync_out[n];
            cnt_q[n]  <= '0;
          end else begin
            cnt_q[n] <= cnt_q[n] + 1'b1;
          end
        end else begin
          cnt_q[n] <= '0;
        end
      end
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync_out;
`endif

  always_comb begin
    pin_en = '0;
    for (int n = 0; n < NUM_PINS; n++) pin_en[n] = (mode_q[n] != M_HIZ);
  end

  // Hi-Z pins read as 0; gating events with pin_en hides the forced 1->0 on a switch to hi-Z.
  assign cond_eff = cond & pin_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= cond_eff;
      pend_q <= (pend_q & ~evt_clr_i) | ((cond_eff ^ prev_q) & pin_en);
      irq_q  <= |(pend_q & evt_mask_i);
    end
  end

  assign core_in_o   = cond_eff;
  assign uart_rxd_o  = (mode_q[UART_RX_PIN] == M_PERIPH) ? cond[UART_RX_PIN] : 1'b1;
  assign cfg_rdata_o = rdata_q;
  assign pad_oe_o    = oe_q & ~{NUM_PINS{rst_i}};
  assign pad_o       = po_q & ~{NUM_PINS{rst_i}};
  assign evt_pend_o  = pend_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_hdr_pin_ctrl.sv
// Testbench for hdr_pin_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_hdr_pin_ctrl;
  // 12 pins keeps the address 4 bits wide while leaving 12..15 as unmapped addresses.
  localparam int N  = 12;
  localparam int S  = 2;
  localparam int F  = 4;
`ifdef HDR_PIN_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = FILT ? S + F : S;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [1:0]   cfg_mode, cfg_rdata;
  logic [N-1:0] core_out, core_in, pad_in, pad_o, pad_oe, mask, clr, pend;
  logic         txd, rxd, irq;

  int checks = 0;
  int errors = 0;

  hdr_pin_ctrl #(.NUM_PINS(N), .SYNC_STAGES(S), .FILT_CYCLES(F), .UART_TX_PIN(1), .UART_RX_PIN(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_mode_i(cfg_mode),
    .cfg_rdata_o(cfg_rdata), .core_out_i(core_out), .core_in_o(core_in), .pad_i(pad_in),
    .pad_o(pad_o), .pad_oe_o(pad_oe), .uart_txd_i(txd), .uart_rxd_o(rxd),
    .evt_mask_i(mask), .evt_clr_i(clr), .evt_pend_o(pend), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model: pad history queue stands in for the synchroniser, run lengths for the filter.
  logic [1:0]   m_mode [N];
  logic [N-1:0] m_q [$];
  logic [N-1:0] m_filt, m_prev, m_pend, m_oe, m_po;
  int           m_run [N];
  logic         m_irq;
  logic [1:0]   m_rdata;

  function automatic logic [N-1:0] m_en();
    logic [N-1:0] e;
    for (int n = 0; n < N; n++) e[n] = (m_mode[n] != 2'b00);
    return e;
  endfunction

  function automatic logic [N-1:0] m_cond();
    return FILT ? m_filt : m_q[0];
  endfunction

  function automatic logic [N-1:0] m_core_in();
    return m_cond() & m_en();
  endfunction

  function automatic logic m_rxd();
    logic [N-1:0] c;
    c = m_cond();
    return (m_mode[0] == 2'b11) ? c[0] : 1'b1;
  endfunction

  task automatic model_edge();
    logic [N-1:0] ce, en, sy;
    if (rst) begin
      for (int n = 0; n < N; n++) begin m_mode[n] = 2'b00; m_run[n] = 0; end
      m_q = {};
      for (int i = 0; i < S; i++) m_q.push_back('0);
      m_filt = '0; m_prev = '0; m_pend = '0; m_oe = '0; m_po = '0; m_irq = 1'b0; m_rdata = 2'b00;
      return;
    end
    sy = m_q[0];
    en = m_en();
    ce = m_cond() & en;
    m_irq  = |(m_pend & mask);
    m_pend = (m_pend & ~clr) | ((ce ^ m_prev) & en);
    m_prev = ce;
    for (int n = 0; n < N; n++) begin
      if (sy[n] != m_filt[n]) begin
        m_run[n]++;
        if (m_run[n] == F) begin m_filt[n] = sy[n]; m_run[n] = 0; end
      end else m_run[n] = 0;
    end
    m_q.push_back(pad_in);
    void'(m_q.pop_front());
    if (cfg_we && cfg_addr < N) m_mode[cfg_addr] = cfg_mode;
    m_rdata = (cfg_addr < N) ? m_mode[cfg_addr] : 2'b00;
    for (int n = 0; n < N; n++) begin
      m_oe[n] = (m_mode[n] == 2'b10) || (m_mode[n] == 2'b11 && n == 1);
      m_po[n] = (m_mode[n] == 2'b10) ? core_out[n] : ((m_mode[n] == 2'b11 && n == 1) ? txd : 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_mode(input int pin, input logic [1:0] mode);
    cfg_we = 1'b1; cfg_addr = 4'(pin); cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pad_in = '1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (pad_oe !== '0) begin errors++; $display("FAIL reset pad_oe: got %h want 0", pad_oe); end
      checks++; if (pad_o !== '0) begin errors++; $display("FAIL reset pad_o: got %h want 0", pad_o); end
      checks++; if (core_in !== '0) begin errors++; $display("FAIL reset core_in: got %h want 0", core_in); end
      checks++; if (irq !== 1'b0 || pend !== '0) begin errors++; $display("FAIL reset evt: irq %b pend %h want 0", irq, pend); end
      checks++; if (rxd !== 1'b1) begin errors++; $display("FAIL reset uart_rxd: got %b want 1", rxd); end
      checks++; if (cfg_rdata !== 2'b00) begin errors++; $display("FAIL reset rdata: got %b want 00", cfg_rdata); end
    end
  endtask

  task automatic test_output();
    core_out = '0; core_out[5] = 1'b1;
    write_mode(5, 2'b10);
    checks++; if (pad_oe[5] !== 1'b1 || pad_o[5] !== 1'b1) begin errors++; $display("FAIL out_drive: oe %b o %b want 1 1", pad_oe[5], pad_o[5]); end
    checks++; if (cfg_rdata !== 2'b10) begin errors++; $display("FAIL out_rdata: got %b want 10", cfg_rdata); end
    core_out[5] = 1'b0;
    tick();
    checks++; if (pad_o[5] !== 1'b0) begin errors++; $display("FAIL out_follow: got %b want 0", pad_o[5]); end
    write_mode(5, 2'b00);
    checks++; if (pad_oe[5] !== 1'b0) begin errors++; $display("FAIL out_release: got %b want 0", pad_oe[5]); end
  endtask

  task automatic test_uart();
    int n;
    txd = 1'b1;
    write_mode(0, 2'b11);
    write_mode(1, 2'b11);
    checks++; if (pad_oe[1:0] !== 2'b10) begin errors++; $display("FAIL uart_oe: got %b want 10", pad_oe[1:0]); end
    checks++; if (rxd !== 1'b1) begin errors++; $display("FAIL uart_idle: got %b want 1", rxd); end
    txd = 1'b0; tick();
    checks++; if (pad_o[1] !== 1'b0) begin errors++; $display("FAIL uart_tx0: got %b want 0", pad_o[1]); end
    txd = 1'b1; tick();
    checks++; if (pad_o[1] !== 1'b1) begin errors++; $display("FAIL uart_tx1: got %b want 1", pad_o[1]); end
    pad_in[0] = 1'b0;
    n = 0;
    while (rxd !== 1'b0 && n < 20) begin tick(); n++; end
    checks++; if (n != LAT) begin errors++; $display("FAIL uart_rx_latency: got %0d cycles want %0d", n, LAT); end
  endtask

  task automatic test_event();
    int n;
    write_mode(3, 2'b01);
    pad_in[3] = 1'b0; mask = '0; mask[3] = 1'b1;
    repeat (LAT + 3) tick();
    clr = '1; tick(); clr = '0; tick();
    checks++; if (pend[3] !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL evt_idle: pend %b irq %b want 0 0", pend[3], irq); end
    pad_in[3] = 1'b1;
    n = 0;
    while (pend[3] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != LAT + 1) begin errors++; $display("FAIL evt_latency: got %0d cycles want %0d", n, LAT + 1); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL evt_irq: got %b want 1", irq); end
    clr[3] = 1'b1; tick(); clr = '0;
    checks++; if (pend[3] !== 1'b0) begin errors++; $display("FAIL evt_clear: got %b want 0", pend[3]); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL evt_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_set_wins();
    pad_in[3] = 1'b0;
    repeat (LAT) tick();
    checks++; if (pend[3] !== 1'b0) begin errors++; $display("FAIL setwin_pre: got %b want 0", pend[3]); end
    clr[3] = 1'b1; tick(); clr = '0;
    checks++; if (pend[3] !== 1'b1) begin errors++; $display("FAIL setwin: got %b want 1", pend[3]); end
  endtask

  task automatic test_mode00();
    pad_in[3] = 1'b1;
    repeat (LAT + 3) tick();
    clr = '1; tick(); clr = '0;
    write_mode(3, 2'b00);
    checks++; if (core_in[3] !== 1'b0) begin errors++; $display("FAIL hiz_core_in: got %b want 0", core_in[3]); end
    repeat (3) tick();
    checks++; if (pend[3] !== 1'b0) begin errors++; $display("FAIL hiz_no_event: got %b want 0", pend[3]); end
  endtask

  task automatic test_invalid_addr();
    for (int a = N; a < 16; a++) begin
      write_mode(a, 2'b10);
      checks++; if (cfg_rdata !== 2'b00) begin errors++; $display("FAIL badaddr_rdata %0d: got %b want 00", a, cfg_rdata); end
      checks++; if (pad_oe !== m_oe) begin errors++; $display("FAIL badaddr_oe %0d: got %h want %h", a, pad_oe, m_oe); end
    end
    cfg_addr = 4'd3; tick();
    checks++; if (cfg_rdata !== 2'b00) begin errors++; $display("FAIL badaddr_pin3: got %b want 00", cfg_rdata); end
  endtask

`ifdef HDR_PIN_FILTER_EN
  task automatic test_filter();
    logic seen;
    write_mode(3, 2'b01);
    pad_in[3] = 1'b0;
    repeat (LAT + 3) tick();
    clr = '1; tick(); clr = '0;
    pad_in[3] = 1'b1; repeat (3) tick(); pad_in[3] = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); seen = seen | core_in[3] | pend[3]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL filter_short: got %b want 0", seen); end
    pad_in[3] = 1'b1; repeat (4) tick(); pad_in[3] = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); seen = seen | core_in[3]; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL filter_long: got %b want 1", seen); end
  endtask
`else
  task automatic test_pulse();
    logic seen;
    write_mode(3, 2'b01);
    pad_in[3] = 1'b0;
    repeat (LAT + 3) tick();
    pad_in[3] = 1'b1; tick(); pad_in[3] = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen = seen | core_in[3]; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL pulse_pass: got %b want 1", seen); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] tog;
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      cfg_mode = 2'($urandom);
      core_out = N'($urandom);
      for (int n = 0; n < N; n++) tog[n] = ($urandom_range(0, 7) == 0);
      pad_in   = pad_in ^ tog;
      if ($urandom_range(0, 3) == 0) txd = ~txd;
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      clr      = N'($urandom & $urandom & $urandom);
      if (rst) begin
        #1;
        checks++; if (pad_oe !== '0) begin errors++; $display("FAIL rnd_rst_oe c%0d: got %h want 0", c, pad_oe); end
      end
      tick();
      checks++; if (pad_oe !== m_oe) begin errors++; $display("FAIL rnd_oe c%0d: got %h want %h", c, pad_oe, m_oe); end
      checks++; if (pad_o !== m_po) begin errors++; $display("FAIL rnd_o c%0d: got %h want %h", c, pad_o, m_po); end
      checks++; if (core_in !== m_core_in()) begin errors++; $display("FAIL rnd_core_in c%0d: got %h want %h", c, core_in, m_core_in()); end
      checks++; if (rxd !== m_rxd()) begin errors++; $display("FAIL rnd_rxd c%0d: got %b want %b", c, rxd, m_rxd()); end
      checks++; if (cfg_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %b want %b", c, cfg_rdata, m_rdata); end
      checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pend c%0d: got %h want %h", c, pend, m_pend); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, m_irq); end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; core_out = '0;
    pad_in = '0; txd = 1'b1; mask = '0; clr = '0;
    test_reset();
    test_output();
    test_uart();
    test_event();
    test_set_wins();
    test_mode00();
    test_invalid_addr();
`ifdef HDR_PIN_FILTER_EN
    test_filter();
`else
    test_pulse();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
